red_pitaya_daisy_frm_tx: RTL and testbench



---
 rtl/red_pitaya_daisy_frm_tx.sv | 150 +++++++++++++++
 tb/tb_red_pitaya_daisy_frm_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_daisy_frm_tx.sv
`timescale 1ns/1ps
// Daisy-chain message framer: buffers typed 32-bit messages and emits each as a
// 4-word frame (header, payload hi, payload lo, XOR checksum) on the parallel TX port.
module red_pitaya_daisy_frm_tx #(
   parameter int unsigned FIFO_DW  = 4,
   parameter logic [7:0]  HDR_SYNC = 8'hA5
) (
   input  logic        par_clk_i,
   input  logic        par_rstn_i,
   input  logic        en_i,
   input  logic        msg_vld_i,
   input  logic [3:0]  msg_type_i,
   input  logic [31:0] msg_dat_i,
   output logic        msg_rdy_o,
   input  logic        par_rdy_i,
   output logic        par_dv_o,
   output logic [15:0] par_dat_o,
   output logic        busy_o,
   output logic [15:0] frame_cnt_o
);

   localparam int unsigned PW = $clog2(FIFO_DW);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [2:0] {IDLE, HDR, DHI, DLO, CHK} state_t;

   typedef struct packed {
      logic [3:0]  typ;
      logic [31:0] dat;
   } msg_t;

   state_t        state_q, state_d;
   msg_t          fifo_q [FIFO_DW];
   msg_t          fifo_d [FIFO_DW];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   msg_t          hold_q, hold_d;
   logic [3:0]    seq_q, seq_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          par_dv_q, par_dv_d;
   logic [15:0]   par_dat_q, par_dat_d;
   logic          busy_q, busy_d;

   logic          push, pop, xfer, can_start;
   logic [15:0]   hdr;

   assign msg_rdy_o = (cnt_q != CW'(FIFO_DW));

   always_comb begin
      state_d     = state_q;
      fifo_d      = fifo_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      pop         = 1'b0;
      push        = msg_vld_i && msg_rdy_o;
      xfer        = par_dv_q && par_rdy_i;
      can_start   = en_i && (cnt_q != '0);

      case (state_q)
         IDLE: begin
            if (can_start) begin
               pop     = 1'b1;
               state_d = HDR;
            end
         end
         HDR: if (xfer) state_d = DHI;
         DHI: if (xfer) state_d = DLO;
         DLO: if (xfer) state_d = CHK;
         CHK: begin
            if (xfer) begin
               seq_d = seq_q + 4'd1;
               if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
               // chain straight into the next frame so back-to-back frames have no gap
               if (can_start) begin
                  pop     = 1'b1;
                  state_d = HDR;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         fifo_d[wr_ptr_q] = '{typ: msg_type_i, dat: msg_dat_i};
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         hold_d   = fifo_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      // output word is built from next-state values so it is registered, and holds during stalls
      hdr = {HDR_SYNC, seq_d, hold_d.typ};
      case (state_d)
         HDR:     par_dat_d = hdr;
         DHI:     par_dat_d = hold_d.dat[31:16];
         DLO:     par_dat_d = hold_d.dat[15:0];
         CHK:     par_dat_d = hdr ^ hold_d.dat[31:16] ^ hold_d.dat[15:0];
         default: par_dat_d = 16'h0000;
      endcase
      par_dv_d = (state_d != IDLE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
      if (!par_rstn_i) begin
         state_q     <= IDLE;
         for (int i = 0; i < int'(FIFO_DW); i++) fifo_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         seq_q       <= '0;
         frame_cnt_q <= '0;
         par_dv_q    <= 1'b0;
         par_dat_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         par_dv_q    <= par_dv_d;
         par_dat_q   <= par_dat_d;
         busy_q      <= busy_d;
      end
   end

   assign par_dv_o    = par_dv_q;
   assign par_dat_o   = par_dat_q;
   assign busy_o      = busy_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_red_pitaya_daisy_frm_tx.sv
`timescale 1ns/1ps
// Bench for the daisy-chain message framer: table of hand-computed frames plus
// directed sequences for FIFO full, seq wrap, enable drop and async reset.
module tb_red_pitaya_daisy_frm_tx;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        msg_vld = 1'b0;
   logic [3:0]  mtyp = '0;
   logic [31:0] mdat = '0;
   logic        msg_rdy;
   logic        par_rdy = 1'b0;
   logic        dv;
   logic [15:0] dat;
   logic        busy;
   logic [15:0] fcnt;

   red_pitaya_daisy_frm_tx dut (
      .par_clk_i  (clk),
      .par_rstn_i (rstn),
      .en_i       (en),
      .msg_vld_i  (msg_vld),
      .msg_type_i (mtyp),
      .msg_dat_i  (mdat),
      .msg_rdy_o  (msg_rdy),
      .par_rdy_i  (par_rdy),
      .par_dv_o   (dv),
      .par_dat_o  (dat),
      .busy_o     (busy),
      .frame_cnt_o(fcnt)
   );

   always #5 clk = ~clk;

   int          n_tot = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          bp_mode = 1'b0;
   logic        rdy_fix = 1'b0;
   logic [15:0] bp_pat = 16'b0110_1001_1100_1010;
   logic [15:0] words[$];
   int          stamps[$];
   logic        stall = 1'b0;
   logic [15:0] held = '0;

   typedef struct {
      logic [3:0]  typ;
      logic [31:0] dat;
      bit          bp;
      logic [63:0] exp;
   } vec_t;
   vec_t vec[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [63:0] frm(input logic [3:0] s, input logic [3:0] t, input logic [31:0] d);
      logic [15:0] h;
      h = {8'hA5, s, t};
      return {h, d[31:16], d[15:0], h ^ d[31:16] ^ d[15:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      par_rdy = bp_mode ? bp_pat[cyc[3:0]] : rdy_fix;
   end

   // records every word that is about to transfer and checks stalled words hold
   always @(negedge clk) begin
      if (!rstn) begin
         stall <= 1'b0;
      end else begin
         if (stall) chk("hold_stable", {47'd0, dv, dat}, {47'd0, 1'b1, held});
         if (dv && par_rdy) begin
            words.push_back(dat);
            stamps.push_back(cyc);
         end
         stall <= dv && !par_rdy;
         held  <= dat;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [3:0] t, input logic [31:0] d, output bit acc);
      msg_vld = 1'b1;
      mtyp    = t;
      mdat    = d;
      acc     = msg_rdy;
      tick();
      msg_vld = 1'b0;
   endtask

   task automatic wait_words(input int n, input string nm);
      int b = 0;
      while (words.size() < n && b < 400) begin
         tick();
         b++;
      end
      if (words.size() < n) chk({nm, "_timeout"}, 64'(words.size()), 64'(n));
   endtask

   task automatic pop_frame(output logic [63:0] f, output int st0, output int st3);
      f = '0; st0 = 0; st3 = 0;
      if (words.size() >= 4) begin
         st0 = stamps[0];
         st3 = stamps[3];
         f = {words[0], words[1], words[2], words[3]};
         for (int i = 0; i < 4; i++) begin
            void'(words.pop_front());
            void'(stamps.pop_front());
         end
      end
   endtask

   task automatic do_reset;
      rstn    = 1'b0;
      en      = 1'b0;
      msg_vld = 1'b0;
      bp_mode = 1'b0;
      rdy_fix = 1'b0;
      tick();
      tick();
      words.delete();
      stamps.delete();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] f, m;
      int          st0, st3, s0, c0, nacc;
      bit          acc;
      logic [3:0]  qt[$];
      logic [31:0] qd[$];

      vec[0] = '{typ: 4'h3, dat: 32'h12345678, bp: 1'b0, exp: 64'hA503_1234_5678_E14F};
      vec[1] = '{typ: 4'h3, dat: 32'h12345678, bp: 1'b1, exp: 64'hA513_1234_5678_E15F};
      vec[2] = '{typ: 4'hA, dat: 32'hDEADBEEF, bp: 1'b0, exp: 64'hA52A_DEAD_BEEF_C568};
      vec[3] = '{typ: 4'hF, dat: 32'h00000000, bp: 1'b1, exp: 64'hA53F_0000_0000_A53F};
      vec[4] = '{typ: 4'h0, dat: 32'hFFFFFFFF, bp: 1'b0, exp: 64'hA540_FFFF_FFFF_A540};
      vec[5] = '{typ: 4'h5, dat: 32'h0F0F00FF, bp: 1'b0, exp: 64'hA555_0F0F_00FF_AAA5};

      // reset state
      do_reset();
      chk("rst_dv", 64'(dv), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_dat", 64'(dat), 64'd0);
      chk("rst_fcnt", 64'(fcnt), 64'd0);
      chk("rst_msg_rdy", 64'(msg_rdy), 64'd1);

      // table-driven frames, seq advancing 0..5
      en = 1'b1;
      rdy_fix = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bp_mode = vec[i].bp;
         push1(vec[i].typ, vec[i].dat, acc);
         chk($sformatf("vec%0d_acc", i), 64'(acc), 64'd1);
         c0 = cyc;
         if (i == 0) begin
            chk("lat_dv_after_e0", 64'(dv), 64'd0);
            tick();
            chk("lat_hdr_after_e1", {47'd0, dv, dat}, {47'd0, 1'b1, 16'hA503});
         end
         wait_words(4, $sformatf("vec%0d", i));
         pop_frame(f, st0, st3);
         chk($sformatf("vec%0d_frame", i), f, vec[i].exp);
         if (i == 0) begin
            chk("lat_first_xfer", 64'(st0), 64'(c0 + 1));
            chk("lat_last_xfer", 64'(st3), 64'(c0 + 4));
         end
         bp_mode = 1'b0;
         tick();
         chk($sformatf("vec%0d_busy_done", i), 64'(busy), 64'd0);
         chk($sformatf("vec%0d_fcnt", i), 64'(fcnt), 64'(i + 1));
      end

      // FIFO full with stalled transmitter: one in holding register + 4 queued
      do_reset();
      en = 1'b1;
      nacc = 0;
      for (int k = 0; k < 6; k++) begin
         msg_vld = 1'b1;
         mtyp    = 4'(k);
         mdat    = 32'hC0DE_0000 + 32'(k);
         if (msg_rdy) begin
            nacc++;
            qt.push_back(mtyp);
            qd.push_back(mdat);
         end
         tick();
      end
      msg_vld = 1'b0;
      chk("full_accepted", 64'(nacc), 64'd5);
      chk("full_msg_rdy", 64'(msg_rdy), 64'd0);
      chk("full_hdr_held", {47'd0, dv, dat}, {47'd0, 1'b1, 16'hA500});
      rdy_fix = 1'b1;
      wait_words(20, "full_drain");
      s0 = 0;
      for (int k = 0; k < 5; k++) begin
         pop_frame(f, st0, st3);
         if (k == 0) s0 = st0;
         chk($sformatf("full_frame%0d", k), f, frm(4'(k), qt[k], qd[k]));
      end
      chk("full_no_gap", 64'(st3 - s0), 64'd19);
      chk("full_msg_rdy_after", 64'(msg_rdy), 64'd1);

      // seq wrap over 17 frames and checksum consistency
      do_reset();
      en = 1'b1;
      rdy_fix = 1'b1;
      for (int k = 0; k < 17; k++) begin
         push1(4'(k + 2), 32'(k), acc);
         wait_words(4, $sformatf("wrap%0d", k));
         pop_frame(f, st0, st3);
         chk($sformatf("wrap%0d_frame", k), f, frm(4'(k), 4'(k + 2), 32'(k)));
         chk($sformatf("wrap%0d_xor", k), 64'(f[15:0]), 64'(f[63:48] ^ f[47:32] ^ f[31:16]));
      end
      tick();
      chk("wrap_fcnt", 64'(fcnt), 64'd17);

      // enable dropped during DHI with two messages queued
      do_reset();
      en = 1'b1;
      rdy_fix = 1'b1;
      push1(4'h1, 32'hAAAA_1111, acc);
      push1(4'h2, 32'hBBBB_2222, acc);
      push1(4'h3, 32'hCCCC_3333, acc);
      chk("en_drop_in_dhi", {47'd0, dv, dat}, {47'd0, 1'b1, 16'hAAAA});
      en = 1'b0;
      wait_words(4, "en_drop_cur");
      repeat (10) tick();
      chk("en_drop_no_more", 64'(words.size()), 64'd4);
      chk("en_drop_idle", 64'(busy), 64'd0);
      pop_frame(f, st0, st3);
      chk("en_drop_frame0", f, frm(4'd0, 4'h1, 32'hAAAA_1111));
      en = 1'b1;
      wait_words(8, "en_resume");
      pop_frame(f, st0, st3);
      chk("en_resume_frame1", f, frm(4'd1, 4'h2, 32'hBBBB_2222));
      pop_frame(f, st0, st3);
      chk("en_resume_frame2", f, frm(4'd2, 4'h3, 32'hCCCC_3333));

      // async reset during DLO
      do_reset();
      en = 1'b1;
      rdy_fix = 1'b1;
      push1(4'h9, 32'h0BAD_F00D, acc);
      for (int b = 0; b < 20 && !(dv && dat == 16'hF00D); b++) tick();
      chk("arst_in_dlo", {47'd0, dv, dat}, {47'd0, 1'b1, 16'hF00D});
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_dv", 64'(dv), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_dat", 64'(dat), 64'd0);
      chk("arst_msg_rdy", 64'(msg_rdy), 64'd1);
      tick();
      tick();
      words.delete();
      stamps.delete();
      rstn = 1'b1;
      tick();
      push1(4'h6, 32'h1357_2468, acc);
      wait_words(4, "arst_after");
      pop_frame(f, st0, st3);
      m = frm(4'd0, 4'h6, 32'h1357_2468);
      chk("arst_seq0_frame", f, m);
      tick();
      chk("arst_fcnt", 64'(fcnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
